// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl
// Sequencing controller for the equalizer FIR bank. Owns the circular sample
// queue pointers, writes each incoming sample, and once a full window is held
// runs one read/accumulate pass of DEPTH cycles per new sample.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   vld        one-cycle strobe, new sample on queue write-data bus
//   wr_en      queue write enable (combinational)
//   wr_addr    queue write address (write pointer)
//   rd_addr    queue read address, oldest to newest during a pass
//   sequencing high for DEPTH cycles per pass, drives all FIR bands
//   fltr_vld   one-cycle pulse, FIR outputs settled
//   full       queue holds DEPTH samples, sticky until reset
//   ovr        sticky overrun flag, a sample arrived mid-pass and was dropped
//
// state | meaning
// ------+------------------------------------------------------------
// FILL  | queue not yet holding a full window; samples written, no pass
// IDLE  | window full, waiting for the next sample
// SEQ   | pass in progress, read address walks oldest to newest
// DONE  | pass finished, filter outputs valid; may accept next sample
module fir_seq_ctrl #(
  parameter int DEPTH  = 1021,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sequencing,
  output logic              fltr_vld,
  output logic              full,
  output logic              ovr
);

  // One extra bit so the fill count can represent DEPTH itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              enter_seq;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (vld && (cnt_q == CNT_LAST)) state_d = SEQ;
      IDLE: if (vld) state_d = SEQ;
      SEQ:  if (tap_q == LAST) state_d = DONE;
      DONE: state_d = vld ? SEQ : IDLE;
      default: state_d = FILL;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    sequencing = 1'b0;
    fltr_vld   = 1'b0;
    case (state_q)
      SEQ:  sequencing = 1'b1;
      DONE: fltr_vld   = 1'b1;
      default: ;
    endcase
  end

  // rst is folded in so the enable drops the instant reset asserts.
  assign wr_en     = vld & ~rst & (state_q != SEQ);
  assign enter_seq = (state_d == SEQ) && (state_q != SEQ);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    tap_d     = tap_q;
    ovr_d     = ovr_q | (vld & (state_q == SEQ));

    if (wr_en) begin
      wr_ptr_d = wrap_inc(wr_ptr_q);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end

    if (enter_seq) begin
      // Post-increment write pointer addresses the oldest sample.
      rd_addr_d = wr_ptr_d;
      tap_d     = '0;
    end else if (state_q == SEQ) begin
      tap_d = tap_q + ADDR_W'(1);
      // Stop stepping on the final tap so the address holds outside SEQ.
      if (tap_q != LAST) rd_addr_d = wrap_inc(rd_addr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_addr_q <= '0;
      tap_q     <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_addr_q <= rd_addr_d;
      tap_q     <= tap_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign wr_addr = wr_ptr_q;
  assign rd_addr = rd_addr_q;
  assign full    = (cnt_q == CNT_FULL);
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              vld;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              sequencing;
  logic              fltr_vld;
  logic              full;
  logic              ovr;

  fir_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .vld        (vld),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .sequencing (sequencing),
    .fltr_vld   (fltr_vld),
    .full       (full),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] rd;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      fl_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Reference bookkeeping derived from the sample stream.
  logic [ADDR_W-1:0] tb_wr_ptr = '0;
  int                tb_cnt = 0;
  int                busy_until = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop expected pass activity as the DUT produces it.
  always @(negedge clk) begin
    rd_exp_t e;
    int      fc;
    if (mon_en && !rst) begin
      if (sequencing === 1'b1) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL seq_unexpected cyc=%0d sequencing=1 expected 0", cyc);
        end else begin
          e = rd_q.pop_front();
          if (e.cyc != cyc || rd_addr !== e.rd) begin
            n_err++;
            $display("FAIL seq_rd cyc=%0d rd_addr=%0d expected cyc=%0d rd_addr=%0d",
                     cyc, rd_addr, e.cyc, e.rd);
          end
        end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        n_vec++;
        n_err++;
        e = rd_q.pop_front();
        $display("FAIL seq_missing cyc=%0d sequencing=%b expected 1", cyc, sequencing);
      end
      if (fltr_vld === 1'b1) begin
        n_vec++;
        if (fl_q.size() == 0) begin
          n_err++;
          $display("FAIL fltr_unexpected cyc=%0d fltr_vld=1 expected 0", cyc);
        end else begin
          fc = fl_q.pop_front();
          if (fc != cyc) begin
            n_err++;
            $display("FAIL fltr_cycle got cyc=%0d expected cyc=%0d", cyc, fc);
          end
        end
      end else if (fl_q.size() != 0 && fl_q[0] <= cyc) begin
        n_vec++;
        n_err++;
        fc = fl_q.pop_front();
        $display("FAIL fltr_missing cyc=%0d fltr_vld=%b expected 1", cyc, fltr_vld);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one vld cycle starting just after a rising edge; checks acceptance
  // and queues the expected pass when this sample completes a window.
  task automatic drive_vld();
    bit exp_acc;
    int t;
    exp_acc = (cyc > busy_until);
    vld = 1'b1;
    @(negedge clk);
    n_vec++;
    if (wr_en !== exp_acc) begin
      n_err++;
      $display("FAIL wr_en cyc=%0d got %b expected %b", cyc, wr_en, exp_acc);
    end
    n_vec++;
    if (wr_addr !== tb_wr_ptr) begin
      n_err++;
      $display("FAIL wr_addr cyc=%0d got %0d expected %0d", cyc, wr_addr, tb_wr_ptr);
    end
    if (exp_acc) begin
      tb_wr_ptr = tb_wr_ptr + 1'b1;
      if (tb_cnt < DEPTH) tb_cnt++;
      if (tb_cnt == DEPTH) begin
        t = cyc;
        for (int k = 1; k <= DEPTH; k++) begin
          rd_exp_t e;
          e.cyc = t + k;
          e.rd  = ADDR_W'((int'(tb_wr_ptr) + k - 1) % DEPTH);
          rd_q.push_back(e);
        end
        fl_q.push_back(t + DEPTH + 1);
        busy_until = t + DEPTH;
      end
    end
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vld = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 vld = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_vec++;
      if ({wr_en, wr_addr, rd_addr, sequencing, fltr_vld, full, ovr} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs got wr_en=%b wr_addr=%0d rd_addr=%0d seq=%b fv=%b full=%b ovr=%b expected all 0",
                 wr_en, wr_addr, rd_addr, sequencing, fltr_vld, full, ovr);
      end
    end
    @(posedge clk);
    #2 vld = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive_vld();
      repeat (2) begin
        @(negedge clk);
        n_vec++;
        if (full !== 1'b0) begin
          n_err++;
          $display("FAIL fill_full sample=%0d got %b expected 0", i, full);
        end
        @(posedge clk);
        #1;
      end
    end
    drive_vld();
    @(negedge clk);
    n_vec++;
    if (full !== 1'b1) begin
      n_err++;
      $display("FAIL full_set got %b expected 1", full);
    end
    @(posedge clk);
    #1;
    idle(10);
  endtask

  task automatic test_steady_wrap();
    drive_vld();
    idle(12);
  endtask

  task automatic test_back_to_back();
    drive_vld();
    idle(DEPTH);
    drive_vld();
    @(negedge clk);
    n_vec++;
    if (sequencing !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_gap got sequencing=%b expected 1", sequencing);
    end
    @(posedge clk);
    #1;
    idle(10);
    n_vec++;
    if (ovr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ovr got %b expected 0", ovr);
    end
  endtask

  task automatic test_overrun();
    logic [ADDR_W-1:0] wa;
    drive_vld();
    idle(2);
    wa = tb_wr_ptr;
    drive_vld();
    @(negedge clk);
    n_vec++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set got %b expected 1", ovr);
    end
    n_vec++;
    if (wr_addr !== wa) begin
      n_err++;
      $display("FAIL ovr_wr_addr got %0d expected %0d", wr_addr, wa);
    end
    @(posedge clk);
    #1;
    idle(8);
    @(negedge clk);
    n_vec++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky got %b expected 1", ovr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pass();
    drive_vld();
    idle(3);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({wr_en, wr_addr, rd_addr, sequencing, fltr_vld, full, ovr} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_async got wr_en=%b wr_addr=%0d rd_addr=%0d seq=%b fv=%b full=%b ovr=%b expected all 0",
               wr_en, wr_addr, rd_addr, sequencing, fltr_vld, full, ovr);
    end
    rd_q.delete();
    fl_q.delete();
    tb_wr_ptr  = '0;
    tb_cnt     = 0;
    busy_until = -1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(12);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive_vld();
      idle(1);
    end
    @(negedge clk);
    n_vec++;
    if (full !== 1'b0) begin
      n_err++;
      $display("FAIL refill_full got %b expected 0", full);
    end
    @(posedge clk);
    #1;
    drive_vld();
    idle(12);
  endtask

  task automatic test_drain();
    n_vec++;
    if (rd_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_seq got %0d pending expected 0", rd_q.size());
    end
    n_vec++;
    if (fl_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_fltr got %0d pending expected 0", fl_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    test_reset();
    test_fill();
    test_steady_wrap();
    test_back_to_back();
    test_overrun();
    test_reset_mid_pass();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencing controller for the equalizer FIR bank. It owns the circular sample queue pointers. It writes each incoming audio sample into the queue and, once the queue holds a full window, runs one read/accumulate pass per new sample. During that pass it drives `sequencing` to every FIR band in parallel (LP/B1/B2/B3/HP) and steps the queue read address from the oldest sample to the newest. It sits between the I2S sample-valid strobe and the FIR band filters, and signals downstream when the filter outputs are settled.

## Interface
- `DEPTH`, 1021: number of taps, equal to the number of queue entries (≥2)
- `ADDR_W`, 10: queue address width; 2^ADDR_W ≥ DEPTH
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `vld`  in  1  one-cycle strobe: new sample present on queue write-data bus
- `wr_en`  out  1  queue write enable (combinational)
- `wr_addr`  out  ADDR_W  queue write address (registered write pointer)
- `rd_addr`  out  ADDR_W  queue read address (registered)
- `sequencing`  out  1  high for exactly DEPTH cycles per pass; drives all FIR bands
- `fltr_vld`  out  1  one-cycle pulse: FIR outputs valid
- `full`  out  1  queue holds DEPTH samples; sticky until reset
- `ovr`  out  1  sticky overrun flag; a sample was dropped

## Operation
- States: FILL, IDLE, SEQ, DONE. Reset state is FILL.
- Sample acceptance: `wr_en = vld & !rst & (state != SEQ)`.
  - When a sample is accepted, `wr_addr` increments at the next edge, wrapping from DEPTH-1 to 0.
- Fill count `cnt` saturates at DEPTH. Once it reaches DEPTH, `full` = 1.
- FILL:
  - Each accepted `vld` increments `cnt`.
  - If `cnt == DEPTH-1` and `vld`, go to SEQ; this is the DEPTH-th sample.
  - Otherwise stay in FILL. No `sequencing` is issued in FILL.
- IDLE: on `vld`, go to SEQ.
- On every entry to SEQ, `rd_addr` loads the post-increment write pointer, which is the oldest sample. `tap` counter clears to 0.
- SEQ:
  - `sequencing` = 1.
  - `rd_addr` increments each cycle, wrapping DEPTH-1 to 0.
  - `tap` increments each cycle.
  - When `tap == DEPTH-1`, go to DONE.
- DONE:
  - `sequencing` = 0, `fltr_vld` = 1.
  - If `vld`, the sample is accepted and the next state is SEQ (back-to-back pass).
  - Otherwise go to IDLE.
- Overrun: `vld` while in SEQ is not written, and `wr_addr` is unchanged. `ovr` sets at the next edge and stays set until reset.
- `rd_addr` holds its last value outside SEQ.
- `sequencing` and `fltr_vld` are decoded from registered state only, so they are glitch-free.

## Timing
- Reset values: `wr_addr` = 0, `rd_addr` = 0, `sequencing` = 0, `fltr_vld` = 0, `full` = 0, `ovr` = 0, `wr_en` = 0; `cnt` = 0, `tap` = 0.
- Reset behaviour: asserting `rst` mid-pass forces every output to its reset value immediately, not waiting for a clock edge. The queue must then be refilled with DEPTH samples before the next pass.
- Trigger cycle t: `vld` is accepted with `wr_en` = 1 in cycle t itself.
- `sequencing` is high in cycles t+1 through t+DEPTH, giving exactly DEPTH cycles.
- `rd_addr` in cycle t+k equals (wr_ptr_new + k - 1) mod DEPTH, for k = 1..DEPTH.
- `fltr_vld` is high in cycle t+DEPTH+1.
- The earliest next trigger is cycle t+DEPTH+1, in DONE.
- Minimum sample spacing without overrun: DEPTH+1 cycles.
- Pass latency, from `vld` to `fltr_vld`: DEPTH+1 cycles.
- FIR bands accumulate on each cycle that `sequencing` is high. The bands absorb the one-cycle synchronous ROM and queue read latency themselves.

## Test plan
Use DEPTH = 8 and ADDR_W = 3 unless stated otherwise.
- **Reset:** `rst` = 1, with random `vld` → all outputs 0; state FILL.
- **Fill:** 7 `vld` pulses, spaced 3 cycles apart → `wr_addr` steps 0..7, `wr_en` pulses each time, `sequencing` stays 0, `full` = 0.
  - 8th pulse at cycle t → `full` = 1 at t+1.
  - `sequencing` high t+1..t+8, with `rd_addr` = 0,1,…,7.
  - `fltr_vld` = 1 only at t+9.
- **Steady state and wrap:** 9th `vld` (written at address 0) → `rd_addr` sequence 1,2,…,7,0; `fltr_vld` 9 cycles after `vld`.
- **Overrun:** `vld` at trigger+3 → `wr_en` = 0, `wr_addr` unchanged, `ovr` = 1 from next cycle and held.
  - Pass completes normally with 8 `sequencing` cycles.
- **Back-to-back:** `vld` exactly in the DONE cycle → sample accepted, `fltr_vld` = 1 in that cycle, `sequencing` re-asserts the next cycle, no idle gap, `ovr` stays 0.
- **Reset mid-pass:** `rst` pulse during the 4th `sequencing` cycle → `sequencing`, `full`, and `fltr_vld` drop asynchronously, and no `fltr_vld` is ever issued for the aborted pass.
  - The next pass occurs only after 8 new samples.
